// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state encoding and abort data for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned WORD_LEN          = 32;
  localparam int unsigned REG_FILE_ADDR_LEN = 5;

  localparam logic [WORD_LEN-1:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Memory is word addressed; the byte offset bits are dropped.
  function automatic logic [WORD_LEN-1:0] word_align(input logic [WORD_LEN-1:0] addr);
    return {addr[WORD_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer: request/stall generation, timeout abort,
// read-data capture and the sticky error flag.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                access,
  input  logic                we,
  input  logic                ack,
  input  logic [WORD_LEN-1:0] rdata,
  output logic                req,
  output logic                stall,
  output logic [WORD_LEN-1:0] capture,
  output logic                err
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Request is combinational so a same-cycle ack completes the access in IDLE.
  assign req   = !rst && ((state == S_IDLE && access) || state == S_WAIT);
  assign stall = !rst && access && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      capture <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (ack) begin
              state <= S_DONE;
              if (!we) capture <= rdata;
            end else begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          // Ack wins over a timeout landing in the same cycle.
          if (ack) begin
            state <= S_DONE;
            if (!we) capture <= rdata;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= S_DONE;
            err   <= 1'b1;
            if (!we) capture <= ABORT_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: drives the data-memory port, stalls upstream during an
// access and registers the writeback payload (MEM/WB) plus the HI register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic                         comp_en_in,
  input  logic                         mul_en_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  input  logic [WORD_LEN-1:0]          alu_res_in,
  input  logic [WORD_LEN-1:0]          st_val_in,
  input  logic [WORD_LEN-1:0]          high_in,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_LEN-1:0]          mem_addr,
  output logic [WORD_LEN-1:0]          mem_wdata,
  input  logic [WORD_LEN-1:0]          mem_rdata,
  input  logic                         mem_ack,
  output logic                         stall,
  output logic                         wb_en_out,
  output logic                         mem_r_en_out,
  output logic                         comp_en_out,
  output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
  output logic [WORD_LEN-1:0]          alu_res_out,
  output logic [WORD_LEN-1:0]          mem_data_out,
  output logic [WORD_LEN-1:0]          hi_out,
  output logic                         mem_err
);

  logic                access;
  logic [WORD_LEN-1:0] capture;

  assign access    = mem_r_en_in | mem_w_en_in;
  assign mem_we    = mem_w_en_in;
  assign mem_addr  = word_align(alu_res_in);
  assign mem_wdata = st_val_in;

  mem_access_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .access  (access),
    .we      (mem_w_en_in),
    .ack     (mem_ack),
    .rdata   (mem_rdata),
    .req     (mem_req),
    .stall   (stall),
    .capture (capture),
    .err     (mem_err)
  );

  // MEM/WB register: a stalled cycle inserts a bubble and holds the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      comp_en_out  <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else if (stall) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      comp_en_out  <= 1'b0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      comp_en_out  <= comp_en_in;
      dest_out     <= dest_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= '0;
    end else if (mul_en_in && !stall) begin
      hi_out <= high_in;
    end
  end

endmodule
